// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the MEM/WB boundary: load type encodings and
// the common reset / write-enable levels used across the core.
package mem_wb_stage_pkg;

  localparam logic       RstEnable    = 1'b1;
  localparam logic       WriteEnable  = 1'b1;
  localparam logic       WriteDisable = 1'b0;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load formatter: picks the little-endian byte/halfword lane,
// extends it, and flags misaligned halfword/word accesses.
module mem_wb_stage_load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]  ld_type,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[7:0];
    case (addr)
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      2'd3:    w_byte = rdata[31:24];
      default: w_byte = rdata[7:0];
    endcase
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Unknown encodings fall through to LW so the access is still checked.
  always_comb begin
    data     = rdata;
    misalign = 1'b0;
    case (ld_type)
      LD_LB:   data = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  data = {24'h0, w_byte};
      LD_LH: begin
        data     = {{16{w_half[15]}}, w_half};
        misalign = addr[0];
      end
      LD_LHU: begin
        data     = {16'h0, w_half};
        misalign = addr[0];
      end
      default: begin
        data     = rdata;
        misalign = (addr != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats load data, drives the register file
// write port from registered state, and counts instructions entering WB.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             mem_valid_i,
  input  logic [31:0]      mem_pc_i,
  input  logic             mem_we_i,
  input  logic [4:0]       mem_waddr_i,
  input  logic [31:0]      mem_alu_res_i,
  input  logic             mem_load_i,
  input  logic [2:0]       mem_ld_type_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             wb_valid,
  output logic [31:0]      wb_pc,
  output logic             wb_we,
  output logic [4:0]       wb_waddr,
  output logic [31:0]      wb_wdata,
  output logic             wb_adel,
  output logic [CNT_W-1:0] wb_count
);

  logic [31:0]      w_ld_data;
  logic             w_ld_misalign;
  logic             w_adel;
  logic             w_we;
  logic [31:0]      w_wdata;

  logic             r_valid;
  logic [31:0]      r_pc;
  logic             r_we;
  logic [4:0]       r_waddr;
  logic [31:0]      r_wdata;
  logic             r_adel;
  logic [CNT_W-1:0] r_count;

  mem_wb_stage_load_align u_load_align (
    .ld_type  (mem_ld_type_i),
    .addr     (mem_alu_res_i[1:0]),
    .rdata    (mem_rdata_i),
    .data     (w_ld_data),
    .misalign (w_ld_misalign)
  );

  // A misaligned load must never reach the register file.
  assign w_adel  = mem_valid_i & mem_load_i & w_ld_misalign;
  assign w_we    = mem_valid_i & mem_we_i & (mem_waddr_i != 5'd0) & ~w_adel;
  assign w_wdata = mem_load_i ? w_ld_data : mem_alu_res_i;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_we    <= WriteDisable;
      r_waddr <= '0;
      r_wdata <= '0;
      r_adel  <= 1'b0;
      r_count <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_we    <= WriteDisable;
      r_adel  <= 1'b0;
    end else if (!stall_i) begin
      r_valid <= mem_valid_i;
      r_pc    <= mem_pc_i;
      r_we    <= w_we ? WriteEnable : WriteDisable;
      r_waddr <= mem_waddr_i;
      r_wdata <= w_wdata;
      r_adel  <= w_adel;
      if (mem_valid_i) r_count <= r_count + CNT_W'(1);
    end
  end

  assign wb_valid = r_valid;
  assign wb_pc    = r_pc;
  assign wb_we    = r_we;
  assign wb_waddr = r_waddr;
  assign wb_wdata = r_wdata;
  assign wb_adel  = r_adel;
  assign wb_count = r_count;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a 4-bit instruction counter.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i;
  logic        mem_valid_i, mem_we_i, mem_load_i;
  logic [31:0] mem_pc_i, mem_alu_res_i, mem_rdata_i;
  logic [4:0]  mem_waddr_i;
  logic [2:0]  mem_ld_type_i;
  logic        wb_valid, wb_we, wb_adel;
  logic [31:0] wb_pc, wb_wdata;
  logic [4:0]  wb_waddr;
  logic [3:0]  wb_count;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_cnt;

  always #5 clk = ~clk;

  mem_wb_stage #(.CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .mem_valid_i   (mem_valid_i),
    .mem_pc_i      (mem_pc_i),
    .mem_we_i      (mem_we_i),
    .mem_waddr_i   (mem_waddr_i),
    .mem_alu_res_i (mem_alu_res_i),
    .mem_load_i    (mem_load_i),
    .mem_ld_type_i (mem_ld_type_i),
    .mem_rdata_i   (mem_rdata_i),
    .wb_valid      (wb_valid),
    .wb_pc         (wb_pc),
    .wb_we         (wb_we),
    .wb_waddr      (wb_waddr),
    .wb_wdata      (wb_wdata),
    .wb_adel       (wb_adel),
    .wb_count      (wb_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic [4:0] wa, input logic [31:0] res, input logic [31:0] pc);
    mem_valid_i   = 1'b1;
    mem_we_i      = 1'b1;
    mem_load_i    = 1'b0;
    mem_ld_type_i = LD_LW;
    mem_waddr_i   = wa;
    mem_alu_res_i = res;
    mem_pc_i      = pc;
    mem_rdata_i   = 32'hDEADBEEF;
  endtask

  task automatic drive_load(input logic [2:0] t, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [4:0] wa);
    mem_valid_i   = 1'b1;
    mem_we_i      = 1'b1;
    mem_load_i    = 1'b1;
    mem_ld_type_i = t;
    mem_waddr_i   = wa;
    mem_alu_res_i = addr;
    mem_pc_i      = 32'h0000_0400;
    mem_rdata_i   = rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive_alu(5'd1, 32'h11, 32'h100);
    tick();
    checks++;
    if ({wb_valid, wb_pc, wb_we, wb_waddr, wb_wdata, wb_adel, wb_count} !== '0) begin
      errors++;
      $display("FAIL reset_init: got valid=%b pc=%h we=%b waddr=%0d wdata=%h adel=%b cnt=%0d, want all 0",
               wb_valid, wb_pc, wb_we, wb_waddr, wb_wdata, wb_adel, wb_count);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_wdata !== 32'h11 || wb_pc !== 32'h100 || wb_count !== 4'd1) begin
      errors++;
      $display("FAIL reset_first_op: valid=%b wdata=%h pc=%h cnt=%0d, want 1 00000011 00000100 1",
               wb_valid, wb_wdata, wb_pc, wb_count);
    end
    drive_alu(5'd2, 32'h22, 32'h104);
    tick();
    checks++;
    if (wb_count !== 4'd2 || wb_waddr !== 5'd2) begin
      errors++;
      $display("FAIL reset_second_op: cnt=%0d waddr=%0d, want 2 2", wb_count, wb_waddr);
    end
    rst = 1'b1;
    drive_alu(5'd3, 32'h33, 32'h108);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({wb_valid, wb_pc, wb_we, wb_waddr, wb_wdata, wb_adel, wb_count} !== '0) begin
        errors++;
        $display("FAIL reset_mid_stream[%0d]: valid=%b we=%b wdata=%h cnt=%0d, want all 0",
                 i, wb_valid, wb_we, wb_wdata, wb_count);
      end
    end
    rst = 1'b0;
    drive_alu(5'd4, 32'h44, 32'h10C);
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_waddr !== 5'd4 || wb_wdata !== 32'h44 || wb_count !== 4'd1) begin
      errors++;
      $display("FAIL reset_release: valid=%b we=%b waddr=%0d wdata=%h cnt=%0d, want 1 1 4 00000044 1",
               wb_valid, wb_we, wb_waddr, wb_wdata, wb_count);
    end
    exp_cnt = 4'd1;
  endtask

  task automatic test_byte_loads();
    logic [2:0]  t_tab [4] = '{LD_LB, LD_LBU, LD_LB, LD_LBU};
    logic [31:0] a_tab [4] = '{32'h1003, 32'h1003, 32'h1000, 32'h1002};
    logic [31:0] e_tab [4] = '{32'hFFFFFF80, 32'h00000080, 32'h00000034, 32'h000000FF};
    for (int i = 0; i < 4; i++) begin
      drive_load(t_tab[i], a_tab[i], 32'h80FF1234, 5'd7);
      tick();
      exp_cnt++;
      checks++;
      if (wb_wdata !== e_tab[i] || wb_we !== 1'b1 || wb_adel !== 1'b0 || wb_count !== exp_cnt) begin
        errors++;
        $display("FAIL byte_load[%0d]: wdata=%h we=%b adel=%b cnt=%0d, want %h 1 0 %0d",
                 i, wb_wdata, wb_we, wb_adel, wb_count, e_tab[i], exp_cnt);
      end
    end
  endtask

  task automatic test_half_word_loads();
    logic [2:0]  t_tab [6] = '{LD_LH, LD_LHU, LD_LH, LD_LW, LD_LW, 3'b111};
    logic [31:0] a_tab [6] = '{32'h2002, 32'h2002, 32'h2001, 32'h2002, 32'h2000, 32'h2000};
    logic [31:0] e_tab [6] = '{32'hFFFF8001, 32'h00008001, 32'h0, 32'h0, 32'h80010000, 32'h80010000};
    logic        w_tab [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive_load(t_tab[i], a_tab[i], 32'h80010000, 5'd9);
      tick();
      exp_cnt++;
      checks++;
      if (wb_we !== w_tab[i] || wb_adel !== ~w_tab[i] || wb_valid !== 1'b1 ||
          (w_tab[i] && wb_wdata !== e_tab[i])) begin
        errors++;
        $display("FAIL hw_load[%0d]: wdata=%h we=%b adel=%b valid=%b, want %h %b %b 1",
                 i, wb_wdata, wb_we, wb_adel, wb_valid, e_tab[i], w_tab[i], ~w_tab[i]);
      end
    end
  endtask

  task automatic test_stall();
    drive_alu(5'd5, 32'h1234, 32'h200);
    tick();
    exp_cnt++;
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_load(LD_LH, 32'h3001 + i, $urandom, 5'd10 + 5'(i));
      tick();
      checks++;
      if (wb_waddr !== 5'd5 || wb_wdata !== 32'h1234 || wb_we !== 1'b1 || wb_valid !== 1'b1 ||
          wb_adel !== 1'b0 || wb_pc !== 32'h200 || wb_count !== exp_cnt) begin
        errors++;
        $display("FAIL stall_hold[%0d]: waddr=%0d wdata=%h we=%b adel=%b pc=%h cnt=%0d, want 5 00001234 1 0 00000200 %0d",
                 i, wb_waddr, wb_wdata, wb_we, wb_adel, wb_pc, wb_count, exp_cnt);
      end
    end
    stall_i = 1'b0;
  endtask

  task automatic test_flush();
    drive_load(LD_LH, 32'h4001, 32'h12345678, 5'd11);
    tick();
    exp_cnt++;
    checks++;
    if (wb_adel !== 1'b1 || wb_we !== 1'b0) begin
      errors++;
      $display("FAIL flush_setup: adel=%b we=%b, want 1 0", wb_adel, wb_we);
    end
    flush_i = 1'b1; stall_i = 1'b1;
    drive_alu(5'd6, 32'h66, 32'h300);
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_adel !== 1'b0 || wb_count !== exp_cnt) begin
      errors++;
      $display("FAIL flush_over_stall: valid=%b we=%b adel=%b cnt=%0d, want 0 0 0 %0d",
               wb_valid, wb_we, wb_adel, wb_count, exp_cnt);
    end
    flush_i = 1'b0; stall_i = 1'b0;
    tick();
    exp_cnt++;
    checks++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_wdata !== 32'h66 || wb_count !== exp_cnt) begin
      errors++;
      $display("FAIL flush_recover: valid=%b we=%b wdata=%h cnt=%0d, want 1 1 00000066 %0d",
               wb_valid, wb_we, wb_wdata, wb_count, exp_cnt);
    end
  endtask

  task automatic test_zero_and_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_valid_i = 1'b0;
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_count !== 4'd0) begin
      errors++;
      $display("FAIL bubble: valid=%b we=%b cnt=%0d, want 0 0 0", wb_valid, wb_we, wb_count);
    end
    for (int i = 0; i < 17; i++) begin
      drive_alu(5'(i), 32'h500 + i, 32'h600 + 4 * i);
      tick();
      if (i == 0) begin
        checks++;
        if (wb_we !== 1'b0 || wb_valid !== 1'b1 || wb_count !== 4'd1) begin
          errors++;
          $display("FAIL zero_reg: we=%b valid=%b cnt=%0d, want 0 1 1", wb_we, wb_valid, wb_count);
        end
      end
    end
    checks++;
    if (wb_count !== 4'd1 || wb_we !== 1'b1 || wb_waddr !== 5'd16) begin
      errors++;
      $display("FAIL count_wrap: cnt=%0d we=%b waddr=%0d, want 1 1 16", wb_count, wb_we, wb_waddr);
    end
  endtask

  initial begin
    test_reset();
    test_byte_loads();
    test_half_word_loads();
    test_stall();
    test_flush();
    test_zero_and_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register between the MEM stage and the register file write port.
- Captures the MEM-stage result and formats load data: byte/halfword extraction, sign or zero extension, alignment check.
- Drives the register file's waddr/wdata/we from registered state.
- Handles stall and flush from the hazard/exception unit and keeps a counter of instructions entering WB.

Parameters:
- CNT_W, 32, width of the wb_count instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- stall_i  in  1  hold WB register contents this cycle
- flush_i  in  1  insert bubble into WB this cycle
- mem_valid_i  in  1  MEM stage holds a real instruction
- mem_pc_i  in  32  PC of MEM instruction
- mem_we_i  in  1  instruction writes a GPR
- mem_waddr_i  in  5  destination GPR
- mem_alu_res_i  in  32  ALU result; for loads, the effective address
- mem_load_i  in  1  instruction is a load
- mem_ld_type_i  in  3  load type (see Decomposition)
- mem_rdata_i  in  32  data-memory read word, valid in the same cycle as the MEM instruction
- wb_valid  out  1  WB holds a real instruction
- wb_pc  out  32  PC of WB instruction
- wb_we  out  1  register file write enable
- wb_waddr  out  5  register file write address
- wb_wdata  out  32  register file write data
- wb_adel  out  1  misaligned load detected for WB instruction
- wb_count  out  CNT_W  instructions captured into WB

Behaviour:
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency: one cycle from MEM inputs to WB outputs.

Priority at each posedge clk:
1. rst=1: all outputs cleared to 0, including wb_count.
2. flush_i=1: wb_valid, wb_we and wb_adel cleared to 0; the other outputs are don't-care and are held. Flush beats stall. wb_count is unchanged.
3. stall_i=1: all outputs hold their values; wb_count is unchanged.
4. Otherwise: capture.
   - wb_valid = mem_valid_i.
   - wb_pc = mem_pc_i.
   - wb_waddr = mem_waddr_i.
   - wb_count increments by 1 if mem_valid_i=1, wrapping to 0 after all ones.

Write data on capture:
- Non-load: wb_wdata = mem_alu_res_i.
- Load: bytes are little-endian; lane k = mem_rdata_i[8k+7:8k], where k = mem_alu_res_i[1:0].
  - LW: full word.
  - LB / LBU: lane k, sign- or zero-extended.
  - LH / LHU: halfword at mem_alu_res_i[1] (bits 15:0 or 31:16), sign- or zero-extended.

Alignment check:
- Misaligned if LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
- On misalignment: wb_adel=1 and wb_we=0.
- Otherwise wb_adel=0.

Write enable on capture:
- wb_we = mem_valid_i & mem_we_i & (mem_waddr_i!=0) & ~misaligned.
- When wb_we=0 the register file sees no write, so the write-to-read bypass cannot trigger.

Other rules:
- An undefined ld_type with mem_load_i=1 is treated as LW.
- Reset asserted mid-stall or mid-flush: reset wins; the first capture after rst deasserts is a normal capture.

Decomposition:
- Shared defines file:
  - LD_LW=3'b000, LD_LB=3'b001, LD_LBU=3'b010, LD_LH=3'b011, LD_LHU=3'b100.
  - Reuse existing RstEnable and WriteEnable constants.
- One natural sub-module: load_align, purely combinational. Inputs: ld_type, addr[1:0], rdata. Outputs: formatted data and misalign flag. It is instantiated in front of the capture register.

Test Plan:
1. Reset: stream valid ALU ops, assert rst for 2 cycles mid-stream -> next posedge all outputs 0, wb_count=0; after release, the first op appears one cycle later with wb_count=1.
2. Byte loads: rdata=0x80FF1234, addr=0x...03.
   - LB -> wb_wdata=0xFFFFFF80, wb_we=1.
   - LBU -> 0x00000080.
   - addr=0x...00, LB -> 0x00000034.
3. Halfword/word loads: rdata=0x80010000.
   - LH at addr ..2 -> 0xFFFF8001.
   - LHU at ..2 -> 0x00008001.
   - LH at ..1 -> wb_we=0, wb_adel=1.
   - LW at ..2 -> wb_we=0, wb_adel=1.
4. Stall: capture ALU op (waddr=5, data=0x1234), then stall_i=1 for 3 cycles with changing inputs -> outputs stay waddr=5, wdata=0x1234, we=1; wb_count is constant.
5. Flush vs stall: flush_i=1 and stall_i=1 in the same cycle -> wb_valid=0, wb_we=0, wb_adel=0; wb_count unchanged.
6. $0 write and counter wrap, with CNT_W=4:
   - ALU op with waddr=0 -> wb_we=0, wb_valid=1.
   - 17 valid captures -> wb_count reads 1 (wrapped 15->0).
